// File: rtl/dual_port_memory_pkg.sv
// Shared constants for the dual-port memory.
// Word size, default depth and per-port FSM encodings.
package dual_port_memory_pkg;

  localparam int WORD_SIZE     = 16;
  localparam int MEM_DEPTH_DEF = 256;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mem_port_fsm.sv
// One memory port: request capture, latency counter,
// write-commit strobe and tristate read-data drive.
module mem_port_fsm
  import dual_port_memory_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 ready,
  output logic                 err_set,
  output logic                 wr_en,
  output logic [AW-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0] wr_data,
  input  logic [WORD_SIZE-1:0] rd_data
);

  logic [1:0]           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  // High address bits wrap around onto the array.
  if (AW < WORD_SIZE) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^address[WORD_SIZE-1:AW];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_set = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (readM ^ writeM) begin
          state_d = ST_BUSY;
          cnt_d   = 3'(LATENCY - 1);
          op_wr_d = writeM;
          addr_d  = address[AW-1:0];
          if (writeM) wdata_d = data;
        end else if (readM && writeM) begin
          err_set = 1'b1;
        end
      end
      (state_q == ST_BUSY): begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
          if (!op_wr_q) rdata_d = rd_data;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      (state_q == ST_DONE): state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready    = (state_q == ST_DONE);
  assign wr_en    = (state_q == ST_BUSY) && (cnt_q == 3'd0)
                    && op_wr_q;
  assign mem_addr = addr_q;
  assign wr_data  = wdata_q;

  assign data = (ready && !op_wr_q) ? rdata_q : 'z;

endmodule

// File: rtl/dual_port_memory.sv
// Two-port word memory with fixed access latency,
// d-port priority on colliding writes and sticky error.
module dual_port_memory
  import dual_port_memory_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready,
  output logic                 err
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic                 i_err, d_err;
  logic                 i_we, d_we;
  logic [AW-1:0]        i_ma, d_ma;
  logic [WORD_SIZE-1:0] i_wd, d_wd;
  logic [WORD_SIZE-1:0] i_rd, d_rd;
  logic                 err_q, err_d;

  logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

  mem_port_fsm #(.LATENCY(LATENCY), .AW(AW)) u_i (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .readM   (i_readM),
    .writeM  (i_writeM),
    .address (i_address),
    .data    (i_data),
    .ready   (i_ready),
    .err_set (i_err),
    .wr_en   (i_we),
    .mem_addr(i_ma),
    .wr_data (i_wd),
    .rd_data (i_rd)
  );

  mem_port_fsm #(.LATENCY(LATENCY), .AW(AW)) u_d (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .readM   (d_readM),
    .writeM  (d_writeM),
    .address (d_address),
    .data    (d_data),
    .ready   (d_ready),
    .err_set (d_err),
    .wr_en   (d_we),
    .mem_addr(d_ma),
    .wr_data (d_wd),
    .rd_data (d_rd)
  );

  assign i_rd = mem_q[i_ma];
  assign d_rd = mem_q[d_ma];

  // Array is not reset; the later d-port write wins a collision.
  always_ff @(posedge Clk) begin
    if (i_we) mem_q[i_ma] <= i_wd;
    if (d_we) mem_q[d_ma] <= d_wd;
  end

  always_comb begin
    err_d = err_q | i_err | d_err;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Directed bench for dual_port_memory, LATENCY=2, depth 256.
// Buses idle high via tri1 so an undriven bus reads 16'hFFFF.
module tb_dual_port_memory;
  import dual_port_memory_pkg::*;

  logic                 Clk = 1'b0;
  logic                 Reset_N = 1'b0;
  logic                 i_readM = 1'b0, i_writeM = 1'b0;
  logic                 d_readM = 1'b0, d_writeM = 1'b0;
  logic [WORD_SIZE-1:0] i_address = '0, d_address = '0;
  logic [WORD_SIZE-1:0] i_drv = '0, d_drv = '0;
  logic                 i_oe = 1'b0, d_oe = 1'b0;
  logic                 i_ready, d_ready, err;
  tri1  [WORD_SIZE-1:0] i_data, d_data;

  localparam logic [15:0] IDLE_BUS = 16'hFFFF;

  int n_run  = 0;
  int n_fail = 0;

  assign i_data = i_oe ? i_drv : 'z;
  assign d_data = d_oe ? d_drv : 'z;

  always #5 Clk = ~Clk;

  dual_port_memory #(.LATENCY(2), .MEM_DEPTH(256)) dut (
    .Clk      (Clk),
    .Reset_N  (Reset_N),
    .i_readM  (i_readM),
    .i_writeM (i_writeM),
    .i_address(i_address),
    .i_data   (i_data),
    .i_ready  (i_ready),
    .d_readM  (d_readM),
    .d_writeM (d_writeM),
    .d_address(d_address),
    .d_data   (d_data),
    .d_ready  (d_ready),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic irm, input logic iwm,
                       input logic [15:0] ia, input logic [15:0] iv,
                       input logic drm, input logic dwm,
                       input logic [15:0] da, input logic [15:0] dv);
    i_readM = irm; i_writeM = iwm; i_address = ia;
    i_drv = iv; i_oe = iwm;
    d_readM = drm; d_writeM = dwm; d_address = da;
    d_drv = dv; d_oe = dwm;
    tick();
    i_readM = 0; i_writeM = 0; i_oe = 0;
    d_readM = 0; d_writeM = 0; d_oe = 0;
  endtask

  task automatic do_write(input bit is_d, input logic [15:0] a,
                          input logic [15:0] v);
    if (is_d) issue(0, 0, 0, 0, 0, 1, a, v);
    else      issue(0, 1, a, v, 0, 0, 0, 0);
    tick(); tick(); tick();
  endtask

  task automatic do_read(input bit is_d, input logic [15:0] a,
                         input logic [15:0] exp, input string tag);
    if (is_d) issue(0, 0, 0, 0, 1, 0, a, 0);
    else      issue(1, 0, a, 0, 0, 0, 0, 0);
    chk({tag, "_busy_bus"}, is_d ? d_data : i_data, IDLE_BUS);
    tick();
    chk({tag, "_busy2_bus"}, is_d ? d_data : i_data, IDLE_BUS);
    tick();
    chk({tag, "_rdy"}, {15'd0, is_d ? d_ready : i_ready}, 16'd1);
    chk({tag, "_data"}, is_d ? d_data : i_data, exp);
    tick();
    chk({tag, "_idle_bus"}, is_d ? d_data : i_data, IDLE_BUS);
  endtask

  initial begin
    #12;
    chk("rst_i_ready", {15'd0, i_ready}, 16'd0);
    chk("rst_d_ready", {15'd0, d_ready}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_i_bus", i_data, IDLE_BUS);
    chk("rst_d_bus", d_data, IDLE_BUS);
    tick();
    Reset_N = 1'b1;
    tick();

    // d-write 0x1234 to 0x0010, ready exactly LATENCY after capture
    issue(0, 0, 0, 0, 0, 1, 16'h0010, 16'h1234);
    chk("wr10_t1", {15'd0, d_ready}, 16'd0);
    tick();
    chk("wr10_t2", {15'd0, d_ready}, 16'd0);
    tick();
    chk("wr10_done", {15'd0, d_ready}, 16'd1);
    chk("wr10_bus", d_data, IDLE_BUS);
    tick();
    chk("wr10_after", {15'd0, d_ready}, 16'd0);
    do_read(1, 16'h0010, 16'h1234, "rd10");

    // colliding writes: d-port wins
    issue(0, 1, 16'h0020, 16'hAAAA, 0, 1, 16'h0020, 16'h5555);
    tick(); tick();
    chk("col_i_rdy", {15'd0, i_ready}, 16'd1);
    chk("col_d_rdy", {15'd0, d_ready}, 16'd1);
    chk("col_i_bus", i_data, IDLE_BUS);
    tick();
    do_read(1, 16'h0020, 16'h5555, "rd20");
    do_read(0, 16'h0020, 16'h5555, "ird20");

    // read and write commit on the same edge: read sees old value
    do_write(1, 16'h0030, 16'h1111);
    issue(1, 0, 16'h0030, 0, 0, 1, 16'h0030, 16'h2222);
    tick(); tick();
    chk("rw_i_rdy", {15'd0, i_ready}, 16'd1);
    chk("rw_d_rdy", {15'd0, d_ready}, 16'd1);
    chk("rw_old", i_data, 16'h1111);
    tick();
    do_read(0, 16'h0030, 16'h2222, "rw_new");

    // address wrap
    do_read(1, 16'h0110, 16'h1234, "wrap");
    do_write(0, 16'h00FF, 16'hBEEF);
    do_read(1, 16'h03FF, 16'hBEEF, "wrap_ff");

    // read+write together: error, no access
    issue(0, 0, 0, 0, 1, 1, 16'h0050, 16'h0000);
    chk("err_set", {15'd0, err}, 16'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("err_nordy%0d", k), {15'd0, d_ready}, 16'd0);
      tick();
    end
    chk("err_sticky", {15'd0, err}, 16'd1);
    #2 Reset_N = 1'b0;
    #1;
    chk("err_cleared", {15'd0, err}, 16'd0);
    tick();
    Reset_N = 1'b1;
    tick();

    // reset during BUSY abandons the write
    do_write(1, 16'h0040, 16'h0404);
    issue(0, 0, 0, 0, 0, 1, 16'h0040, 16'h7777);
    #1 Reset_N = 1'b0;
    #1;
    chk("abort_rst_rdy", {15'd0, d_ready}, 16'd0);
    tick();
    Reset_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_rdy%0d", k), {15'd0, d_ready}, 16'd0);
      chk($sformatf("abort_bus%0d", k), d_data, IDLE_BUS);
      tick();
    end
    do_read(1, 16'h0040, 16'h0404, "abort_rd");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_port_memory.md
DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL take parameter LATENCY, default 2, legal range 1..7, as the cycles from request capture to ready.
REQ-002 SHALL take parameter MEM_DEPTH, default 256, as the word count; the array index is the low log2(MEM_DEPTH) address bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named Clk and Reset_N.
REQ-004 SHALL provide the following ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset_N  input  1  asynchronous active-low reset.
- i_readM  input  1  instruction-port read request.
- i_writeM  input  1  instruction-port write request.
- i_address  input  WORD_SIZE  instruction-port address.
- i_data  inout  WORD_SIZE  instruction-port data; driven only when returning read data, otherwise Z.
- i_ready  output  1  instruction-port completion pulse.
- d_readM  input  1  data-port read request.
- d_writeM  input  1  data-port write request.
- d_address  input  WORD_SIZE  data-port address.
- d_data  inout  WORD_SIZE  data-port data; same drive rule as i_data.
- d_ready  output  1  data-port completion pulse.
- err  output  1  sticky protocol-error flag.

Function
REQ-005 SHALL run one independent FSM per port with states IDLE, BUSY and DONE.
REQ-006 In IDLE, on a rising edge where exactly one of readM or writeM is high, the port SHALL capture the op, the address and, for a write, the bus data, then enter BUSY with count = LATENCY-1.
REQ-007 In BUSY, the port SHALL decrement the count each edge and enter DONE on the edge where the count is 0.
REQ-008 For a request captured at edge t, ready SHALL be high exactly during the cycle between edges t+LATENCY and t+LATENCY+1.
REQ-009 DONE SHALL always go to IDLE on the next edge.
REQ-010 Requests SHALL be sampled only in IDLE; asserted request lines are ignored in BUSY and DONE.
REQ-011 Minimum spacing between two captures on one port SHALL be LATENCY+2 cycles.
REQ-012 A write SHALL commit to the array on the edge that enters DONE.
REQ-013 A read SHALL latch array[addr] into a port output register on the edge that enters DONE, and drive it onto the port data bus only while in DONE with op = read.
REQ-014 Reads SHALL observe only writes committed on strictly earlier edges; on a same-edge commit to the same address, the read returns the old value.
REQ-015 On simultaneous write commits to the same address on the same edge, the d-port data SHALL win.
REQ-016 If readM and writeM are both high when sampled in IDLE, the port SHALL remain in IDLE, capture nothing and set err to 1.
REQ-017 err SHALL stay at 1 until reset.
REQ-018 Address bits above the index width SHALL be ignored (wrap-around).

Reset
REQ-019 Asserting Reset_N low SHALL immediately force both FSMs to IDLE, the counts to 0, i_ready, d_ready and err to 0, and both data buses to Z.
REQ-020 Reset mid-operation SHALL abandon any pending access; an uncommitted write never reaches the array.
REQ-021 Array contents SHALL NOT be cleared by reset.

Structure
REQ-022 FSM state encodings and the default MEM_DEPTH SHALL live in the shared constants include; WORD_SIZE SHALL come from that same include.
REQ-023 Per-port logic (FSM, counter, capture registers, tristate drive) SHALL be one sub-module, mem_port_fsm, instantiated twice.
REQ-024 The array and the collision priority logic SHALL stay in dual_port_memory.

Verification
REQ-025 LATENCY=2; d-write 0x1234 to 0x0010 captured at edge 5 -> d_ready high in cycle 7; a later d-read of 0x0010 returns 0x1234 on d_data during its DONE cycle.
REQ-026 Simultaneous i-write 0xAAAA and d-write 0x5555 to 0x0020, both captured at the same edge -> array[0x20] = 0x5555.
REQ-027 i-read of 0x0030 (holding 0x1111) completes on the same edge as a d-write commit of 0x2222 to 0x0030 -> i_data = 0x1111; a subsequent read returns 0x2222.
REQ-028 d_readM and d_writeM both high in IDLE -> d_ready never rises, err = 1 and stays 1; Reset_N low -> err = 0.
REQ-029 d-write 0x7777 to 0x0040 with Reset_N pulsed low while in BUSY -> d_ready never rises, array[0x40] unchanged, d_data = Z.
REQ-030 Read of 0x0110 with MEM_DEPTH=256 -> returns array[0x10]; the data bus is Z in every cycle except DONE.
